// File: rtl/parking_gate_ctrl_pkg.sv
// Shared definitions for the parking-entrance gate controller: FSM states and default access parameters.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PIN  = 3'd1,
    PIN_ALARM = 3'd2,
    GATE_OPEN = 3'd3,
    PASSING   = 3'd4,
    BLOCK     = 3'd5
  } gateState_e;

  localparam logic [7:0]  DEFAULT_PIN       = 8'b00100110;
  localparam int unsigned DEFAULT_MAX_TRIES = 3;

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Sensor / PIN / gate bundle between the parking-lot stimulus side (master) and the gate controller (slave).
interface parking_gate_ctrl_if;

  logic       sensorA;
  logic       sensorB;
  logic [7:0] pass;
  logic       gateState;
  logic       blockAlarm;
  logic       wrongPinAlarm;

  modport master (
    output sensorA, sensorB, pass,
    input  gateState, blockAlarm, wrongPinAlarm
  );

  modport slave (
    input  sensorA, sensorB, pass,
    output gateState, blockAlarm, wrongPinAlarm
  );

endinterface

// File: rtl/parking_gate_ctrl_pin_attempt_det.sv
// PIN attempt detector: an attempt is a non-zero pass value that differs from last cycle's value.
module pin_attempt_det #(
    parameter logic [7:0] PIN = 8'b00100110
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pass,
    output logic       attempt,
    output logic       match
);

    logic [7:0] passQ;

    always_ff @(posedge clk) begin
        if (reset) passQ <= '0;
        else       passQ <= pass;
    end

    // A held code counts once; re-entry needs 0 or another value in between.
    assign attempt = (pass != '0) && (pass != passQ);
    assign match   = attempt && (pass == PIN);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking-entrance gate controller: Moore FSM over entry/gate sensors and PIN attempts, registered outputs.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter logic [7:0]  PIN       = DEFAULT_PIN,
    parameter int unsigned MAX_TRIES = DEFAULT_MAX_TRIES
) (
    input  logic                 clk,
    input  logic                 reset,
    parking_gate_ctrl_if.slave   bus
);

    localparam int unsigned CW = $clog2(MAX_TRIES + 1);

    gateState_e    state, stateNext;
    logic [CW-1:0] tryCnt, tryNext, tryInc;
    logic          attempt, match;
    logic          gateQ, blockQ, wrongQ;

    pin_attempt_det #(.PIN(PIN)) uDet (
        .clk     (clk),
        .reset   (reset),
        .pass    (bus.pass),
        .attempt (attempt),
        .match   (match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            tryCnt <= '0;
            gateQ  <= 1'b0;
            blockQ <= 1'b0;
            wrongQ <= 1'b0;
        end else begin
            state  <= stateNext;
            tryCnt <= tryNext;
            // Outputs decoded from the next state so they line up with the state register.
            gateQ  <= (stateNext == GATE_OPEN) || (stateNext == PASSING);
            blockQ <= (stateNext == BLOCK);
            wrongQ <= (stateNext == PIN_ALARM);
        end
    end

    always_comb begin
        stateNext = state;
        tryNext   = tryCnt;
        tryInc    = (tryCnt == CW'(MAX_TRIES)) ? tryCnt : tryCnt + CW'(1);
        case (state)
            IDLE: begin
                tryNext = '0;
                if (bus.sensorA) stateNext = WAIT_PIN;
            end
            WAIT_PIN: begin
                // An attempt outranks sensorA dropping in the same cycle.
                if (match) begin
                    stateNext = GATE_OPEN;
                    tryNext   = '0;
                end else if (attempt) begin
                    tryNext = tryInc;
                    if (tryInc == CW'(MAX_TRIES)) stateNext = PIN_ALARM;
                end else if (!bus.sensorA) begin
                    stateNext = IDLE;
                    tryNext   = '0;
                end
            end
            PIN_ALARM: begin
                if (match) begin
                    stateNext = GATE_OPEN;
                    tryNext   = '0;
                end
            end
            GATE_OPEN: begin
                if (bus.sensorA && bus.sensorB) stateNext = BLOCK;
                else if (bus.sensorB)           stateNext = PASSING;
            end
            PASSING: begin
                if (bus.sensorA && bus.sensorB) stateNext = BLOCK;
                else if (!bus.sensorB)          stateNext = IDLE;
            end
            BLOCK: begin
                if (match) stateNext = GATE_OPEN;
            end
            default: begin
                stateNext = IDLE;
                tryNext   = '0;
            end
        endcase
    end

    assign bus.gateState     = gateQ;
    assign bus.blockAlarm    = blockQ;
    assign bus.wrongPinAlarm = wrongQ;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl; each check compares {gateState, blockAlarm, wrongPinAlarm}.
module tb_parking_gate_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [2:0] obs;

    parking_gate_ctrl_if bus ();

    parking_gate_ctrl #(.PIN(8'h26), .MAX_TRIES(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {bus.gateState, bus.blockAlarm, bus.wrongPinAlarm};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset       = 1'b1;
        bus.sensorA = 1'b0;
        bus.sensorB = 1'b0;
        bus.pass    = 8'h00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: got %b required 000", obs);
        end
    endtask

    task automatic test_nominal();
        doReset();
        bus.sensorA = 1'b1; tick();
        bus.pass = 8'hFF; tick(); tick();
        bus.pass = 8'h3E; tick(); tick();
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL nominal_before_pin: got %b required 000", obs);
        end
        bus.pass = 8'h26; tick();
        checks++;
        if (obs !== 3'b100) begin
            errors++;
            $display("FAIL nominal_open: got %b required 100", obs);
        end
        bus.sensorA = 1'b0; bus.sensorB = 1'b1; tick();
        checks++;
        if (obs !== 3'b100) begin
            errors++;
            $display("FAIL nominal_passing: got %b required 100", obs);
        end
        bus.sensorB = 1'b0; tick();
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL nominal_closed: got %b required 000", obs);
        end
        tick();
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL nominal_idle_stays: got %b required 000", obs);
        end
        bus.pass = 8'h00;
    endtask

    task automatic test_lockout();
        doReset();
        bus.sensorA = 1'b1; tick();
        bus.pass = 8'h01; tick();
        bus.pass = 8'h02; tick();
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL lockout_two_wrong: got %b required 000", obs);
        end
        bus.pass = 8'h03; tick();
        checks++;
        if (obs !== 3'b001) begin
            errors++;
            $display("FAIL lockout_third_wrong: got %b required 001", obs);
        end
        bus.pass = 8'h04; tick();
        checks++;
        if (obs !== 3'b001) begin
            errors++;
            $display("FAIL lockout_fourth_wrong: got %b required 001", obs);
        end
        bus.sensorA = 1'b0; bus.sensorB = 1'b1; tick();
        checks++;
        if (obs !== 3'b001) begin
            errors++;
            $display("FAIL lockout_ignores_sensors: got %b required 001", obs);
        end
        bus.sensorB = 1'b0;
        bus.pass = 8'h26; tick();
        checks++;
        if (obs !== 3'b100) begin
            errors++;
            $display("FAIL lockout_release: got %b required 100", obs);
        end
        bus.pass = 8'h00;
    endtask

    task automatic test_held_value();
        doReset();
        bus.sensorA = 1'b1; tick();
        bus.pass = 8'h11;
        repeat (10) tick();
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL held_no_alarm: got %b required 000", obs);
        end
        bus.pass = 8'h00; tick();
        bus.pass = 8'h11; tick();
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL held_second_count: got %b required 000", obs);
        end
        // Third distinct attempt must trip the alarm only if the held value counted exactly once.
        bus.pass = 8'h12; tick();
        checks++;
        if (obs !== 3'b001) begin
            errors++;
            $display("FAIL held_third_alarm: got %b required 001", obs);
        end
        bus.pass = 8'h00;
    endtask

    task automatic test_tailgating();
        doReset();
        bus.sensorA = 1'b1; tick();
        bus.pass = 8'h26; tick();
        bus.sensorB = 1'b1; tick();
        checks++;
        if (obs !== 3'b010) begin
            errors++;
            $display("FAIL tailgate_block: got %b required 010", obs);
        end
        bus.pass = 8'h55; tick();
        checks++;
        if (obs !== 3'b010) begin
            errors++;
            $display("FAIL tailgate_wrong_ignored: got %b required 010", obs);
        end
        bus.pass = 8'h56; tick();
        bus.pass = 8'h57; tick();
        checks++;
        if (obs !== 3'b010) begin
            errors++;
            $display("FAIL tailgate_not_counted: got %b required 010", obs);
        end
        bus.pass = 8'h00; tick();
        bus.pass = 8'h26; tick();
        checks++;
        if (obs !== 3'b100) begin
            errors++;
            $display("FAIL tailgate_release: got %b required 100", obs);
        end
        bus.sensorA = 1'b0; tick();
        bus.sensorA = 1'b1; tick();
        checks++;
        if (obs !== 3'b010) begin
            errors++;
            $display("FAIL tailgate_from_passing: got %b required 010", obs);
        end
        bus.pass = 8'h00;
    endtask

    task automatic test_simultaneous();
        doReset();
        bus.sensorA = 1'b1; tick();
        bus.sensorA = 1'b0; bus.pass = 8'h26; tick();
        checks++;
        if (obs !== 3'b100) begin
            errors++;
            $display("FAIL attempt_beats_sensor_drop: got %b required 100", obs);
        end
        bus.pass = 8'h00;
    endtask

    task automatic test_abandon();
        doReset();
        bus.sensorA = 1'b1; tick();
        bus.pass = 8'h01; tick();
        bus.pass = 8'h00; bus.sensorA = 1'b0; tick();
        bus.sensorA = 1'b1; tick();
        bus.pass = 8'h02; tick();
        bus.pass = 8'h03; tick();
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL abandon_counter_cleared: got %b required 000", obs);
        end
        bus.pass = 8'h04; tick();
        checks++;
        if (obs !== 3'b001) begin
            errors++;
            $display("FAIL abandon_third_alarm: got %b required 001", obs);
        end
        bus.pass = 8'h00;
    endtask

    task automatic test_reset_midop();
        doReset();
        bus.sensorA = 1'b1; tick();
        bus.pass = 8'h26; tick();
        bus.sensorA = 1'b0; bus.sensorB = 1'b1; tick();
        checks++;
        if (obs !== 3'b100) begin
            errors++;
            $display("FAIL midop_in_passing: got %b required 100", obs);
        end
        reset = 1'b1; tick();
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL midop_reset: got %b required 000", obs);
        end
        reset = 1'b0; bus.sensorB = 1'b0; bus.pass = 8'h00; tick();
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL midop_after_reset_idle: got %b required 000", obs);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        bus.sensorA = 1'b0;
        bus.sensorB = 1'b0;
        bus.pass    = 8'h00;
        test_reset();
        test_nominal();
        test_lockout();
        test_held_value();
        test_tailgating();
        test_simultaneous();
        test_abandon();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
